// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with combinational read ports, multi-port
// writeback, optional write-to-read forwarding and a pending-write scoreboard.

module regfile_rd_port #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                addr,
  input  logic [NREG-1:0][XLEN-1:0]    regs,
  input  logic [NREG-1:0]              pend,
  input  logic [NWR-1:0]               wr_act,
  input  logic [NWR-1:0][AW-1:0]       wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]     wr_data,
  output logic [XLEN-1:0]              data,
  output logic                         busy
);
  logic            byp_hit;
  logic [XLEN-1:0] byp_data;

  // Later ports overwrite earlier matches, so the highest-index writer is forwarded.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_act[w] && wr_addr[w] == addr) begin
        byp_hit  = 1'b1;
        byp_data = wr_data[w];
      end
    end
  end

  always_comb begin
    data = regs[addr];
    busy = pend[addr];
    if (addr == '0) begin
      data = '0;
      busy = 1'b0;
    end else if (BYPASS != 0 && byp_hit) begin
      data = byp_data;
      busy = 1'b0;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int             XLEN   = 64,
  parameter int             NREG   = 32,
  parameter int             AW     = $clog2(NREG),
  parameter int             NRD    = 2,
  parameter int             NWR    = 1,
  parameter int             BYPASS = 1,
  parameter logic [XLEN-1:0] RSTVAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_ready,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_vec
);
  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NREG-1:0]           pend;
  logic [NREG-1:0]           pend_nxt;
  logic [NWR-1:0][AW-1:0]    wa;
  logic [NWR-1:0][XLEN-1:0]  wd;
  logic [NWR-1:0]            wr_act;
  logic                      iss_hit;
  logic                      accept;

  assign wa = wr_addr;
  assign wd = wr_data;

  for (genvar w = 0; w < NWR; w++) begin : g_wact
    assign wr_act[w] = wr_en[w] && (wa[w] != '0);
  end

  always_comb begin
    iss_hit = 1'b0;
    for (int w = 0; w < NWR; w++)
      if (wr_act[w] && wa[w] == iss_rd) iss_hit = 1'b1;
  end

  // A writeback landing this cycle frees the destination for a new writer.
  assign iss_ready = (iss_rd == '0) || !pend[iss_rd] || iss_hit;
  assign accept    = iss_valid && iss_ready && !flush;

  // Clear by writeback first, then set by issue, so set wins on collision.
  always_comb begin
    pend_nxt = pend;
    for (int w = 0; w < NWR; w++)
      if (wr_act[w]) pend_nxt[wa[w]] = 1'b0;
    if (flush)
      pend_nxt = '0;
    else if (accept && iss_rd != '0)
      pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= '0;
      for (int r = 0; r < NREG; r++)
        mem[r] <= (r == 0) ? '0 : RSTVAL;
    end else begin
      pend <= pend_nxt;
      for (int w = 0; w < NWR; w++)
        if (wr_act[w]) mem[wa[w]] <= wd[w];
    end
  end

  assign busy_vec = pend;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)
    ) u_rd (
      .addr    (rd_addr[k*AW +: AW]),
      .regs    (mem),
      .pend    (pend),
      .wr_act  (wr_act),
      .wr_addr (wa),
      .wr_data (wd),
      .data    (rd_data[k*XLEN +: XLEN]),
      .busy    (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share
// stimulus and are checked every cycle against an array-based reference model.

module tb_regfile_scoreboard;
  localparam int XLEN = 64, NREG = 32, AW = 5, NRD = 2, NWR = 2;
  localparam logic [63:0] RST_B = 64'hA5;

  logic                clock = 0;
  logic                reset = 0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                iss_valid = 0;
  logic [AW-1:0]       iss_rd = '0;
  logic                flush = 0;

  logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NRD-1:0]      rd_busy_a, rd_busy_b;
  logic                iss_ready_a, iss_ready_b;
  logic [NREG-1:0]     busy_vec_a, busy_vec_b;

  int checks = 0, errors = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR),
                       .BYPASS(1), .RSTVAL(64'h0)) dut_a (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_a),
    .flush(flush), .busy_vec(busy_vec_a));

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR),
                       .BYPASS(0), .RSTVAL(RST_B)) dut_b (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_b),
    .flush(flush), .busy_vec(busy_vec_b));

  always #5 clock = ~clock;

  // Reference state: architectural values per instance and one pending bit per register.
  logic [63:0] mem_a [NREG];
  logic [63:0] mem_b [NREG];
  logic [NREG-1:0] pend_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] wa(input int w);
    logic [NWR*AW-1:0] v = wr_addr;
    return v[w*AW +: AW];
  endfunction

  function automatic logic [63:0] wdat(input int w);
    logic [NWR*XLEN-1:0] v = wr_data;
    return v[w*XLEN +: XLEN];
  endfunction

  function automatic logic [AW-1:0] ra(input int k);
    logic [NRD*AW-1:0] v = rd_addr;
    return v[k*AW +: AW];
  endfunction

  function automatic logic write_hits(input logic [AW-1:0] a);
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wa(w) != 0 && wa(w) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_ready();
    return (iss_rd == 0) || !pend_m[iss_rd] || write_hits(iss_rd);
  endfunction

  task automatic model_read(input bit byp, input logic [AW-1:0] a,
                            output logic [63:0] d, output logic b);
    d = byp ? mem_a[a] : mem_b[a];
    b = pend_m[a];
    if (a == 0) begin
      d = 0; b = 0;
    end else if (byp) begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wa(w) == a) begin d = wdat(w); b = 0; end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_m = '0;
      for (int r = 0; r < NREG; r++) begin
        mem_a[r] = 0;
        mem_b[r] = (r == 0) ? 64'h0 : RST_B;
      end
    end else begin
      logic [NREG-1:0] np;
      logic acc;
      np  = pend_m;
      acc = iss_valid && model_ready() && !flush;
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wa(w) != 0) begin
          mem_a[wa(w)] = wdat(w);
          mem_b[wa(w)] = wdat(w);
          np[wa(w)] = 1'b0;
        end
      if (flush) np = '0;
      else if (acc && iss_rd != 0) np[iss_rd] = 1'b1;
      pend_m = np;
    end
  end

  always @(negedge clock) begin
    logic [63:0] d;
    logic b;
    chk("busy_vec_a", {32'h0, busy_vec_a}, {32'h0, pend_m});
    chk("busy_vec_b", {32'h0, busy_vec_b}, {32'h0, pend_m});
    chk("iss_ready_a", {63'h0, iss_ready_a}, {63'h0, model_ready()});
    chk("iss_ready_b", {63'h0, iss_ready_b}, {63'h0, model_ready()});
    for (int k = 0; k < NRD; k++) begin
      model_read(1'b1, ra(k), d, b);
      chk("rd_data_a", rd_data_a[k*XLEN +: XLEN], d);
      chk("rd_busy_a", {63'h0, rd_busy_a[k]}, {63'h0, b});
      model_read(1'b0, ra(k), d, b);
      chk("rd_data_b", rd_data_b[k*XLEN +: XLEN], d);
      chk("rd_busy_b", {63'h0, rd_busy_b[k]}, {63'h0, b});
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    wr_en = '0; iss_valid = 0; flush = 0;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [63:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  initial begin
    #1 reset = 1;
    #20 reset = 0;
    step();
    set_rd(0, 5); #1;
    chk("rst_busy_vec", {32'h0, busy_vec_a}, 64'h0);
    chk("rst_ready", {63'h0, iss_ready_a}, 64'h1);
    chk("rst_x5_b", rd_data_b[63:0], 64'hA5);

    // x0 write and x0 issue are both no-ops
    set_wr(0, 0, 64'hFFFF); iss_valid = 1; iss_rd = 0; set_rd(0, 0); #1;
    chk("x0_ready", {63'h0, iss_ready_a}, 64'h1);
    step(); idle(); #1;
    chk("x0_rd", rd_data_a[63:0], 64'h0);
    chk("x0_busy", {63'h0, busy_vec_a[0]}, 64'h0);

    // same-cycle forwarding vs. stored read
    set_wr(0, 3, 64'hDEAD); set_rd(0, 3); #1;
    chk("byp_a", rd_data_a[63:0], 64'hDEAD);
    chk("byp_busy_a", {63'h0, rd_busy_a[0]}, 64'h0);
    chk("nobyp_old_b", rd_data_b[63:0], 64'hA5);
    step(); idle(); #1;
    chk("nobyp_new_b", rd_data_b[63:0], 64'hDEAD);

    // scoreboard set, hazard, writeback-with-reissue, final clear
    iss_valid = 1; iss_rd = 7;
    step(); #1;
    chk("sb_busy7", {63'h0, busy_vec_a[7]}, 64'h1);
    chk("sb_hazard", {63'h0, iss_ready_a}, 64'h0);
    set_wr(0, 7, 64'h77); #1;
    chk("sb_wb_ready", {63'h0, iss_ready_a}, 64'h1);
    step(); idle(); #1;
    chk("sb_stay7", {63'h0, busy_vec_a[7]}, 64'h1);
    set_wr(1, 7, 64'h78);
    step(); idle(); #1;
    chk("sb_clr7", {63'h0, busy_vec_a[7]}, 64'h0);

    // two ports on the same register: higher index wins
    set_wr(0, 9, 64'h1); set_wr(1, 9, 64'h2); set_rd(1, 9); #1;
    chk("conf_byp", rd_data_a[127:64], 64'h2);
    step(); idle(); #1;
    chk("conf_store", rd_data_b[127:64], 64'h2);

    // flush clears pending, blocks issue, keeps the write
    iss_valid = 1; iss_rd = 1; step();
    iss_rd = 4; step();
    iss_rd = 8; step(); idle(); #1;
    chk("fl_pre", {32'h0, busy_vec_a}, 64'h112);
    flush = 1; iss_valid = 1; iss_rd = 10; set_wr(0, 4, 64'h44); set_rd(0, 4);
    step(); idle(); #1;
    chk("fl_busy", {32'h0, busy_vec_a}, 64'h0);
    chk("fl_x4", rd_data_b[63:0], 64'h44);

    // asynchronous reset mid-cycle with x5 pending and written
    set_wr(0, 5, 64'h55); step(); idle();
    iss_valid = 1; iss_rd = 5; step(); idle(); iss_rd = 5; set_rd(0, 5);
    #1 chk("pre_rst_busy5", {63'h0, busy_vec_a[5]}, 64'h1);
    #1 reset = 1;
    #1;
    chk("mid_rst_busy", {32'h0, busy_vec_a}, 64'h0);
    chk("mid_rst_x5_a", rd_data_a[63:0], 64'h0);
    chk("mid_rst_x5_b", rd_data_b[63:0], 64'hA5);
    chk("mid_rst_ready", {63'h0, iss_ready_a}, 64'h1);
    @(negedge clock); #2 reset = 0;
    step();

    // randomized traffic on a narrow address range to force collisions
    for (int i = 0; i < 3000; i++) begin
      wr_en     = NWR'($urandom_range(0, 3));
      wr_addr   = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      wr_data   = {$urandom, $urandom, $urandom, $urandom};
      rd_addr   = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = AW'($urandom_range(0, 11));
      flush     = $urandom_range(0, 15) == 0;
      step();
    end
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
